muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; SHALL support any even WIDTH from 8 to 64.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: start_in  input  1  request strobe, sampled each rising edge.
REQ-005 Port: op_in  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
REQ-006 Port: data1_in  input  WIDTH  multiplicand, dividend, or MTHI/MTLO source.
REQ-007 Port: data2_in  input  WIDTH  multiplier or divisor.
REQ-008 Port: hi_out  output  WIDTH  HI register: product upper half or remainder.
REQ-009 Port: lo_out  output  WIDTH  LO register: product lower half or quotient.
REQ-010 Port: busy_out  output  1  high while an operation is in progress.
REQ-011 Port: done_out  output  1  one-cycle pulse when HI/LO receive a new MULT/DIV result.

Function
REQ-012 FSM SHALL have three states: IDLE, CALC, FIX; busy_out SHALL be 1 exactly when state is not IDLE.
REQ-013 start_in SHALL be accepted only in IDLE; start_in in CALC or FIX SHALL be ignored, with no effect on state or operands.
REQ-014 Accepted op 0-3 at edge k: latch operands (magnitudes for signed ops, plus sign flags), clear the iteration counter, go to CALC.
REQ-015 CALC SHALL run exactly WIDTH iterations, one per edge: shift-add for multiply, restoring shift-subtract for divide; move to FIX on the last iteration (edge k+WIDTH).
REQ-016 FIX, edge k+WIDTH+1: apply sign correction, write hi_out/lo_out, return to IDLE, set done_out=1 for that single cycle.
REQ-017 Latency SHALL be fixed at WIDTH+1 cycles for all of ops 0-3, including divide by zero; busy_out is high WIDTH+1 cycles.
REQ-018 hi_out/lo_out SHALL hold previous values throughout CALC and FIX; no partial result is visible.
REQ-019 MULT/MULTU: {hi_out,lo_out} = full 2*WIDTH product, two's-complement (MULT) or unsigned (MULTU).
REQ-020 DIV: quotient truncates toward zero; remainder takes the dividend's sign; quotient is negative iff the operand signs differ and the quotient is nonzero.
REQ-021 DIVU: lo_out = unsigned quotient, hi_out = unsigned remainder.
REQ-022 Divisor zero (op 2 or 3): lo_out = all ones, hi_out = data1_in as latched.
REQ-023 DIV of most-negative value by -1: lo_out = most-negative value, hi_out = 0; no other flag.
REQ-024 MTHI/MTLO accepted in IDLE SHALL write data1_in to hi_out/lo_out at that edge, stay IDLE, and leave done_out and busy_out at 0.
REQ-025 Ops 6-7 SHALL be ignored completely.
REQ-026 start_in in the same cycle as done_out=1 SHALL be accepted, because the FSM is already IDLE.

Reset
REQ-027 rst_n=0 at an edge SHALL force IDLE with hi_out=0, lo_out=0, busy_out=0, done_out=0, counter=0; this takes priority over start_in.
REQ-028 Reset during CALC/FIX SHALL abort the operation; the next cycle SHALL produce no done_out pulse and no HI/LO write.

Verification (WIDTH=32)
REQ-029 MULTU 0xFFFFFFFF x 0x2 -> busy_out high 33 cycles; then hi_out=0x00000001, lo_out=0xFFFFFFFE, done_out pulses 1 cycle.
REQ-030 MULT -3 x 5 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1; DIV -7 / 2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
REQ-031 DIVU 7 / 0 -> lo_out=0xFFFFFFFF, hi_out=0x00000007 after 33 cycles; DIV 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
REQ-032 MTHI 0x12345678 while idle -> next cycle hi_out=0x12345678, busy_out=0, done_out=0; the same MTHI issued mid-DIVU -> ignored, and the DIVU result is written normally.
REQ-033 Second start_in during CALC -> ignored, first result unchanged; start_in on the done_out cycle -> accepted, with busy_out high the next cycle.
REQ-034 rst_n=0 at CALC iteration 10 -> hi_out=lo_out=0, busy_out=0, and no done_out pulse thereafter.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One multiply (shift-add) or restoring divide step per cycle over WIDTH
// cycles, then a single fix-up cycle applies sign correction and writes HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic [2:0]       op_in,
  input  logic [WIDTH-1:0] data1_in,
  input  logic [WIDTH-1:0] data2_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  // Per-operation control latched at accept time.
  typedef struct packed {
    logic is_div;
    logic sgn;
    logic neg_a;
    logic neg_b;
    logic b_zero;
  } op_ctrl_t;

  state_t            state_q, state_d;
  op_ctrl_t          ctrl_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  acc_hi_q;   // product upper half / partial remainder
  logic [WIDTH-1:0]  acc_lo_q;   // multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0]  opnd_q;     // multiplicand or divisor magnitude

  logic              in_sgn, in_neg_a, in_neg_b;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic              last_iter;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_sh;
  logic              div_ok;
  logic              res_neg;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]  quo_fix, rem_fix;

  assign busy_out  = (state_q != IDLE);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Operand magnitudes and sign flags for the incoming request.
  assign in_sgn   = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign in_neg_a = in_sgn & data1_in[WIDTH-1];
  assign in_neg_b = in_sgn & data2_in[WIDTH-1];
  assign mag_a    = in_neg_a ? -data1_in : data1_in;
  assign mag_b    = in_neg_b ? -data2_in : data2_in;

  // One iteration step: add-then-shift for multiply, trial subtract for divide.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ok  = (div_sh >= {1'b0, opnd_q});

  // Sign fix-up applied in the FIX cycle on the magnitude result.
  assign res_neg  = ctrl_q.sgn & (ctrl_q.neg_a ^ ctrl_q.neg_b);
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = res_neg ? -prod : prod;
  assign quo_fix  = res_neg ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = ctrl_q.neg_a ? -acc_hi_q : acc_hi_q;

  // Next-state logic; only arithmetic ops leave IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_in && !op_in[2]) state_d = CALC;
      CALC: if (last_iter) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath: operand latch, iteration, and HI/LO write-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_out   <= '0;
      lo_out   <= '0;
      done_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state_q)
        IDLE: if (start_in) begin
          case (op_in)
            OP_MULT, OP_MULTU: begin
              ctrl_q   <= '{is_div: 1'b0, sgn: in_sgn, neg_a: in_neg_a,
                            neg_b: in_neg_b, b_zero: (data2_in == '0)};
              cnt_q    <= '0;
              acc_hi_q <= '0;
              acc_lo_q <= mag_b;
              opnd_q   <= mag_a;
            end
            OP_DIV, OP_DIVU: begin
              ctrl_q   <= '{is_div: 1'b1, sgn: in_sgn, neg_a: in_neg_a,
                            neg_b: in_neg_b, b_zero: (data2_in == '0)};
              cnt_q    <= '0;
              acc_hi_q <= '0;
              acc_lo_q <= mag_a;
              opnd_q   <= mag_b;
            end
            OP_MTHI: hi_out <= data1_in;
            OP_MTLO: lo_out <= data1_in;
            default: ;
          endcase
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (ctrl_q.is_div) begin
            acc_hi_q <= div_ok ? WIDTH'(div_sh - {1'b0, opnd_q}) : div_sh[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ok};
          end else begin
            {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[WIDTH-1:1]};
          end
        end
        FIX: begin
          done_out <= 1'b1;
          if (!ctrl_q.is_div) begin
            {hi_out, lo_out} <= prod_fix;
          end else if (ctrl_q.b_zero) begin
            // Zero divisor: the remainder path has accumulated |dividend|,
            // so restoring its sign returns the original dividend.
            lo_out <= '1;
            hi_out <= rem_fix;
          end else begin
            lo_out <= quo_fix;
            hi_out <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against an arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_in;
  logic [2:0]   op_in;
  logic [W-1:0] data1_in, data2_in;
  logic [W-1:0] hi_out, lo_out;
  logic         busy_out, done_out;

  int n_chk = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .op_in(op_in),
    .data1_in(data1_in), .data2_in(data2_in),
    .hi_out(hi_out), .lo_out(lo_out), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation definition.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    h = '0; l = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = ua * ub;      h = p[63:32]; l = p[31:0]; end
      3'd2: if (b == 0) begin l = '1; h = a; end
            else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
      3'd3: if (b == 0) begin l = '1; h = a; end
            else begin p = ua / ub; l = p[31:0]; p = ua % ub; h = p[31:0]; end
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start_in = 1'b1; op_in = op; data1_in = a; data2_in = b;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  // Counts remaining busy cycles, then checks the done cycle's results.
  task automatic wait_done(input string tag, input int exp_n,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
    int n = 0;
    while (busy_out && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_n));
    chk({tag, "_done"}, 64'(done_out), 64'd1);
    chk({tag, "_hi"}, 64'(hi_out), 64'(eh));
    chk({tag, "_lo"}, 64'(lo_out), 64'(el));
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    model(op, a, b, eh, el);
    start_op(op, a, b);
    wait_done(tag, LAT, eh, el);
    @(negedge clk);
    chk({tag, "_done_fall"}, 64'(done_out), 64'd0);
  endtask

  initial begin
    logic [W-1:0] eh, el, eh2, el2, ph, pl, a, b;
    int saw;
    rst_n = 1'b0; start_in = 1'b0; op_in = '0; data1_in = '0; data2_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases.
    run_op("multu_ff_x2", 3'd1, 32'hFFFF_FFFF, 32'h2);
    chk("multu_ff_x2_const", {32'(hi_out), 32'(lo_out)}, 64'h0000_0001_FFFF_FFFE);
    run_op("mult_m3x5", 3'd0, -32'sd3, 32'sd5);
    chk("mult_m3x5_const", {32'(hi_out), 32'(lo_out)}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("div_m7d2", 3'd2, -32'sd7, 32'sd2);
    chk("div_m7d2_const", {32'(hi_out), 32'(lo_out)}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_7d0", 3'd3, 32'd7, 32'd0);
    chk("divu_7d0_const", {32'(hi_out), 32'(lo_out)}, 64'h0000_0007_FFFF_FFFF);
    run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_min_m1_const", {32'(hi_out), 32'(lo_out)}, 64'h0000_0000_8000_0000);
    run_op("div_m9d0", 3'd2, -32'sd9, 32'd0);
    run_op("div_m9dm4", 3'd2, -32'sd9, -32'sd4);

    // MTHI / MTLO while idle.
    start_op(3'd4, 32'h1234_5678, 32'h0);
    chk("mthi_hi", 64'(hi_out), 64'h1234_5678);
    chk("mthi_busy", 64'(busy_out), 64'd0);
    chk("mthi_done", 64'(done_out), 64'd0);
    start_op(3'd5, 32'hCAFE_F00D, 32'h0);
    chk("mtlo_lo", 64'(lo_out), 64'hCAFE_F00D);
    chk("mtlo_hi_kept", 64'(hi_out), 64'h1234_5678);
    chk("mtlo_done", 64'(done_out), 64'd0);

    // Reserved ops do nothing.
    start_op(3'd6, 32'h5555_5555, 32'h1);
    start_op(3'd7, 32'hAAAA_AAAA, 32'h1);
    chk("rsvd_busy", 64'(busy_out), 64'd0);
    chk("rsvd_hi", 64'(hi_out), 64'h1234_5678);
    chk("rsvd_lo", 64'(lo_out), 64'hCAFE_F00D);

    // MTHI mid-DIVU is ignored; HI/LO hold during the operation.
    model(3'd3, 32'd100, 32'd7, eh, el);
    start_op(3'd3, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start_op(3'd4, 32'h1234_5678, 32'h0);
    chk("mid_hold_hi", 64'(hi_out), 64'h1234_5678);
    chk("mid_hold_lo", 64'(lo_out), 64'hCAFE_F00D);
    wait_done("mid_mthi", LAT - 5, eh, el);

    // Second start during CALC is ignored; start on the done cycle is taken.
    model(3'd0, 32'hFFFF_FF00, 32'h0001_0001, eh, el);
    model(3'd3, 32'hDEAD_BEEF, 32'h0000_0013, eh2, el2);
    @(negedge clk);
    start_op(3'd0, 32'hFFFF_FF00, 32'h0001_0001);
    repeat (2) @(negedge clk);
    start_op(3'd1, 32'h7777_7777, 32'h3);
    wait_done("ign_start", LAT - 3, eh, el);
    start_op(3'd3, 32'hDEAD_BEEF, 32'h0000_0013);
    chk("b2b_busy", 64'(busy_out), 64'd1);
    wait_done("b2b", LAT, eh2, el2);

    // Reset mid-CALC aborts with no later done pulse.
    @(negedge clk);
    start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_hi", 64'(hi_out), 64'd0);
    chk("abort_lo", 64'(lo_out), 64'd0);
    chk("abort_busy", 64'(busy_out), 64'd0);
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_out || busy_out) saw++;
    end
    chk("abort_no_done", 64'(saw), 64'd0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [2:0] op;
      op = 3'($urandom_range(0, 3));
      r = $urandom_range(0, 4);
      a = $urandom;
      b = $urandom;
      if (r == 0) b = '0;
      if (r == 1) b = 32'($signed($urandom_range(0, 30)) - 15);
      if (r == 2) a = 32'($signed($urandom_range(0, 200)) - 100);
      if (r == 3) begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h1; end
      ph = hi_out; pl = lo_out;
      model(op, a, b, eh, el);
      start_op(op, a, b);
      chk($sformatf("rnd%0d_hold", i), {32'(hi_out), 32'(lo_out)}, {32'(ph), 32'(pl)});
      wait_done($sformatf("rnd%0d_op%0d", i, op), LAT - 1 + 1, eh, el);
      @(negedge clk);
      chk($sformatf("rnd%0d_done_fall", i), 64'(done_out), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
